// File: rtl/clock_period_meter.sv
// Clock period meter: measures the rising-edge-to-rising-edge period of i_sig, and the
// time it is high within that period, both in i_clock cycles. A measurement starts on
// i_start and ends with a one-cycle o_valid pulse, or an o_timeout pulse if no edge arrives.
module clock_period_meter #(
  parameter int unsigned CNT_WIDTH = 24,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_sig,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic                 o_timeout,
  output logic [CNT_WIDTH-1:0] o_period,
  output logic [CNT_WIDTH-1:0] o_high
);

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeasure
  } state_e;

  // A counter holding this value gives up on the next cycle without a rising edge.
  // TIMEOUT never exceeds 2^CNT_WIDTH-1, so the counters cannot wrap.
  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] One     = CNT_WIDTH'(1);

  state_e               r_state;
  logic                 r_s1;
  logic                 r_s2;
  logic                 r_s3;
  logic [CNT_WIDTH-1:0] r_wait_cnt;
  logic [CNT_WIDTH-1:0] r_period_cnt;
  logic [CNT_WIDTH-1:0] r_high_cnt;
  logic [CNT_WIDTH-1:0] r_period;
  logic [CNT_WIDTH-1:0] r_high;
  logic                 r_valid;
  logic                 r_timeout;

  logic                 w_rise;

  assign w_rise = r_s2 & ~r_s3;

  // Two-flop synchronizer for i_sig, plus one history flop for edge detection.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_sig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Measurement FSM: wait for a first rising edge, then count until the next one.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_wait_cnt   <= '0;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_period     <= '0;
      r_high       <= '0;
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        StIdle: begin
          // An edge coinciding with i_start is ignored: edges are only looked at in ARM.
          if (i_start) begin
            r_state    <= StArm;
            r_wait_cnt <= '0;
          end
        end
        StArm: begin
          if (w_rise) begin
            // The rise cycle itself is the first (high) cycle of the period.
            r_state      <= StMeasure;
            r_period_cnt <= One;
            r_high_cnt   <= One;
          end else if (r_wait_cnt == LastCnt) begin
            r_state   <= StIdle;
            r_timeout <= 1'b1;
            r_period  <= '0;
            r_high    <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + One;
          end
        end
        StMeasure: begin
          if (w_rise) begin
            r_state  <= StIdle;
            r_valid  <= 1'b1;
            r_period <= r_period_cnt;
            r_high   <= r_high_cnt;
          end else if (r_period_cnt == LastCnt) begin
            r_state   <= StIdle;
            r_timeout <= 1'b1;
            r_period  <= '0;
            r_high    <= '0;
          end else begin
            r_period_cnt <= r_period_cnt + One;
            if (r_s2) begin
              r_high_cnt <= r_high_cnt + One;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy    = (r_state != StIdle);
  assign o_valid   = r_valid;
  assign o_timeout = r_timeout;
  assign o_period  = r_period;
  assign o_high    = r_high;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: drives per-cycle i_sig waveforms and predicts each
// measurement from the list of synchronized rising edges of that waveform.
module tb_clock_period_meter;

  localparam int unsigned CW   = 16;
  localparam int unsigned TO   = 100;
  localparam int          WLEN = 512;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          sig   = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          valid;
  logic          tmo;
  logic [CW-1:0] per;
  logic [CW-1:0] hi;

  int n_cmp = 0;
  int n_bad = 0;

  // wave[n] is the i_sig value sampled at clock edge n of the current run.
  bit wave[WLEN];
  // Synchronizer contents at or before this edge index are known to be zero (reset).
  int zero_upto = -1;

  clock_period_meter #(
    .CNT_WIDTH(CW),
    .TIMEOUT  (TO)
  ) dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_sig    (sig),
    .i_start  (start),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_timeout(tmo),
    .o_period (per),
    .o_high   (hi)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Value of i_sig as seen through the synchronizer history.
  function automatic bit eff(input int i);
    if (i < 0 || i <= zero_upto || i >= WLEN) return 1'b0;
    return wave[i];
  endfunction

  // The measuring logic sees i_sig two edges late; a rise is a 0->1 step of that view.
  function automatic bit rise_at(input int n);
    return eff(n - 2) && !eff(n - 3);
  endfunction

  function automatic int find_rise(input int after, input int upto);
    for (int n = after + 1; n <= upto; n++) begin
      if (rise_at(n)) return n;
    end
    return -1;
  endfunction

  // kind: 1 = valid result, 2 = timeout; ev is the edge that registers the outcome.
  task automatic predict(input int st, output int kind, output int ev, output int p,
                         output int h);
    int r1;
    int r2;
    p  = 0;
    h  = 0;
    r1 = find_rise(st, st + int'(TO));
    if (r1 < 0) begin
      kind = 2;
      ev   = st + int'(TO);
    end else begin
      r2 = find_rise(r1, r1 + int'(TO) - 1);
      if (r2 < 0) begin
        kind = 2;
        ev   = r1 + int'(TO) - 1;
      end else begin
        kind = 1;
        ev   = r2;
        p    = r2 - r1;
        for (int n = r1; n < r2; n++) h += int'(eff(n - 2));
      end
    end
  endtask

  task automatic gen_periodic(input int hl, input int ll, input int phase);
    for (int i = 0; i < WLEN; i++) begin
      wave[i] = (i < 4) ? 1'b0 : (((i - 4 + phase) % (hl + ll)) < hl);
    end
  endtask

  task automatic gen_step(input int at);
    for (int i = 0; i < WLEN; i++) wave[i] = (i >= at);
  endtask

  task automatic gen_random();
    int i;
    int len;
    bit lvl;
    for (int k = 0; k < 4; k++) wave[k] = 1'b0;
    i   = 4;
    lvl = 1'($urandom_range(0, 1));
    while (i < WLEN) begin
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 120))
                                        : int'($urandom_range(1, 15));
      for (int k = 0; k < len && i < WLEN; k++) begin
        wave[i] = lvl;
        i++;
      end
      lvl = ~lvl;
    end
  endtask

  // One measurement over the current wave. do_reset aborts it three cycles into MEASURE
  // and restarts on the first edge after reset. fix_per < 0 skips the fixed-value check.
  task automatic run_case(input string tag, input int st, input bit extra, input bit do_reset,
                          input int fix_per, input int fix_hi);
    int     kind;
    int     ev;
    int     p;
    int     h;
    int     rst_at   = -1;
    int     st2      = -1;
    int     nval     = 0;
    int     nto      = 0;
    int     nboth    = 0;
    int     first_ev = -1;
    longint ev_per   = 0;
    longint ev_hi    = 0;
    longint ev_busy  = 1;
    zero_upto = -1;
    if (do_reset) begin
      rst_at    = find_rise(st, st + int'(TO)) + 3;
      zero_upto = rst_at;
      st2       = rst_at + 1;
      predict(st2, kind, ev, p, h);
    end else begin
      predict(st, kind, ev, p, h);
    end
    for (int n = 0; n <= ev + 3; n++) begin
      sig   = wave[n];
      rst   = (n == rst_at);
      start = (n == st) || (n == st2) ||
              (extra && n > st && n < ev && $urandom_range(0, 2) == 0);
      @(posedge clk);
      #1;
      if (valid) nval++;
      if (tmo) nto++;
      if (valid && tmo) nboth++;
      if ((valid || tmo) && first_ev < 0) begin
        first_ev = n;
        ev_per   = longint'(per);
        ev_hi    = longint'(hi);
        ev_busy  = longint'(busy);
      end
      if (n == st && !do_reset) check_eq({tag, ":busy_after_start"}, longint'(busy), 1);
      if (n == rst_at) begin
        check_eq({tag, ":busy_after_reset"}, longint'(busy), 0);
        check_eq({tag, ":period_after_reset"}, longint'(per), 0);
        check_eq({tag, ":high_after_reset"}, longint'(hi), 0);
      end
    end
    start = 1'b0;
    rst   = 1'b0;
    check_eq({tag, ":valid_pulses"}, nval, (kind == 1) ? 1 : 0);
    check_eq({tag, ":timeout_pulses"}, nto, (kind == 2) ? 1 : 0);
    check_eq({tag, ":both_pulses"}, nboth, 0);
    check_eq({tag, ":event_edge"}, first_ev, ev);
    check_eq({tag, ":period"}, ev_per, p);
    check_eq({tag, ":high"}, ev_hi, h);
    check_eq({tag, ":busy_at_event"}, ev_busy, 0);
    check_eq({tag, ":period_hold"}, longint'(per), p);
    if (fix_per >= 0) begin
      check_eq({tag, ":spec_period"}, ev_per, fix_per);
      check_eq({tag, ":spec_high"}, ev_hi, fix_hi);
    end
  endtask

  initial begin
    int st;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset:busy", longint'(busy), 0);
    check_eq("reset:valid", longint'(valid), 0);
    check_eq("reset:timeout", longint'(tmo), 0);
    check_eq("reset:period", longint'(per), 0);
    check_eq("reset:high", longint'(hi), 0);
    rst = 1'b0;

    // Start on the very first edge after reset release.
    gen_periodic(5, 5, 0);
    run_case("div10", 0, 1'b0, 1'b0, 10, 5);
    gen_periodic(3, 7, 4);
    run_case("h3l7", 6, 1'b0, 1'b0, 10, 3);
    gen_periodic(1, 1, 0);
    run_case("toggle", 5, 1'b0, 1'b0, 2, 1);
    gen_step(WLEN);
    run_case("stuck_low", 5, 1'b0, 1'b0, 0, 0);
    gen_step(10);
    run_case("stuck_high", 5, 1'b0, 1'b0, 0, 0);
    gen_periodic(5, 5, 3);
    run_case("reset_mid", 4, 1'b0, 1'b1, 10, 5);

    // Start coincident with a synchronized rise, then extra starts while busy.
    gen_periodic(5, 5, 7);
    zero_upto = -1;
    st = 4;
    while (!rise_at(st)) st++;
    run_case("coincident", st, 1'b1, 1'b0, 10, 5);

    for (int it = 0; it < 20; it++) begin
      gen_random();
      run_case($sformatf("rand%0d", it), int'($urandom_range(4, 20)),
               1'($urandom_range(0, 1)), 1'b0, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 Parameter CNT_WIDTH, default 24, SHALL set the bit width of all period/high-time counters and outputs.
REQ-002 Parameter TIMEOUT, default 1000000, SHALL set the maximum number of i_clock cycles to wait in ARM or MEASURE (legal range 4 .. 2^CNT_WIDTH-1).
REQ-003 i_clock  input  1  SHALL be the single system clock (100 MHz nominal); all state updates occur on its rising edge.
REQ-004 i_reset  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of i_clock.
REQ-005 i_sig  input  1  SHALL carry the clock/waveform under measurement, possibly asynchronous to i_clock.
REQ-006 i_start  input  1  SHALL request one measurement when high for a cycle in IDLE.
REQ-007 o_busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-008 o_valid  output  1  SHALL pulse high for exactly one cycle when a measurement completes.
REQ-009 o_timeout  output  1  SHALL pulse high for exactly one cycle when a measurement is abandoned.
REQ-010 o_period  output  CNT_WIDTH  SHALL give the rising-edge-to-rising-edge period of i_sig in i_clock cycles.
REQ-011 o_high  output  CNT_WIDTH  SHALL give the number of i_clock cycles i_sig was high within that period.

Function
REQ-012 i_sig SHALL pass through a 2-flop synchronizer (s1, s2) plus one history flop (s3), all reset to 0.
REQ-013 Rising-edge event rise SHALL be true in any cycle where s2=1 and s3=0.
REQ-014 The FSM SHALL have exactly three states: IDLE, ARM, MEASURE.
REQ-015 IDLE: on i_start=1 SHALL go to ARM and clear the wait counter; an edge coincident with that i_start SHALL be ignored.
REQ-016 ARM: on rise SHALL go to MEASURE with period_cnt=1 and high_cnt=1.
REQ-017 ARM: otherwise SHALL increment the wait counter; when it reaches TIMEOUT, SHALL go to IDLE and pulse o_timeout.
REQ-018 MEASURE, no rise: SHALL increment period_cnt, and SHALL increment high_cnt only when s2=1.
REQ-019 MEASURE, rise: SHALL register o_period<=period_cnt and o_high<=high_cnt, pulse o_valid in the next cycle, and go to IDLE.
REQ-020 MEASURE: if period_cnt reaches TIMEOUT before rise, SHALL go to IDLE, pulse o_timeout, and set o_period=0 and o_high=0.
REQ-021 Counters SHALL never wrap; the TIMEOUT check SHALL occur before any overflow.
REQ-022 The result SHALL be exact for synchronous inputs; for asynchronous inputs the error SHALL be at most ±1 cycle.
REQ-023 Minimum measurable period SHALL be 2 cycles (i_sig toggling every i_clock cycle).
REQ-024 i_start while o_busy=1 SHALL be ignored, with no effect on the measurement in progress.
REQ-025 o_valid and o_timeout SHALL never be high in the same cycle.
REQ-026 o_period and o_high SHALL hold their values until the next o_valid or o_timeout.
REQ-027 o_busy SHALL be low in the cycle that o_valid or o_timeout is high.
REQ-028 Latency SHALL be: first i_sig rising edge + 2 synchronizer cycles + one full period + 1 cycle to o_valid.

Reset
REQ-029 i_reset=1 SHALL, on the next clock edge, force state=IDLE; s1/s2/s3=0; all counters=0; o_busy, o_valid, o_timeout=0; o_period=0 and o_high=0.
REQ-030 Reset asserted during ARM or MEASURE SHALL abort without pulsing o_valid or o_timeout.
REQ-031 After reset is released, the block SHALL accept i_start on the first clock edge.

Verification
REQ-032 i_sig = i_clock/10 (5 high, 5 low, synchronous), pulse i_start -> one o_valid with o_period=10, o_high=5; o_busy then low.
REQ-033 i_sig high 3 / low 7 cycles -> o_period=10, o_high=3; i_sig toggling every cycle -> o_period=2, o_high=1.
REQ-034 TIMEOUT=100, i_sig held 0, pulse i_start -> o_timeout pulse 100 cycles after ARM entry; o_period=0; no o_valid.
REQ-035 TIMEOUT=100, i_sig rises once then stays high -> o_timeout when period_cnt reaches 100; o_period=0, o_high=0.
REQ-036 i_reset asserted mid-MEASURE -> next cycle o_busy=0, o_period=0, no pulses; a subsequent i_start on a /10 input -> o_period=10.
REQ-037 Extra i_start pulses during MEASURE plus i_start coincident with a rise in IDLE -> exactly one o_valid per accepted start; values still 10/5.
